// File: rtl/dmem_wbuf_resp.sv
// Data memory with a posted-write buffer in front of a single-write-port RAM.
// Core stores are queued and drained in order. Loads see the youngest queued
// store to the same word. A host loader shares the RAM write port. The host
// is granted when the buffer is empty, or after it has waited STARVE cycles.
// WORDS is expected to be a power of two, because the word index is a plain
// bit slice of the byte address.
module dmem_wbuf_resp #(
    parameter int WORDS  = 64,
    parameter int WBUF   = 4,
    parameter int STARVE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluoutm,
    input  logic [31:0] writedatam,
    input  logic        memwritem,
    output logic [31:0] readdatam,
    output logic        stallm,
    input  logic        hreq,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic        hack
);

    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W  = (WBUF > 1) ? $clog2(WBUF) : 1;
    localparam int CNT_W  = $clog2(WBUF + 1);
    localparam int WAIT_W = $clog2(STARVE + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WBUF);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(WBUF - 1);
    localparam logic [PTR_W:0]    PTR_MOD  = (PTR_W + 1)'(WBUF);

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_HOST  = 1'b1
    } arb_state_t;

    // Storage: RAM is never reset; buffer payload needs no reset because
    // count/head/tail alone decide which entries are live.
    logic [31:0]      ram      [WORDS];
    logic [IDX_W-1:0] buf_idx  [WBUF];
    logic [31:0]      buf_data [WBUF];

    arb_state_t        state_reg;
    logic              hack_reg;
    logic              live_reg;
    logic [WAIT_W-1:0] waitcnt_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;

    logic [IDX_W-1:0]  core_idx;
    logic [IDX_W-1:0]  host_idx;
    logic              full;
    logic              accept;
    logic              grant;
    logic              drain;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_widx;
    logic [31:0]       ram_wdata;

    logic [PTR_W-1:0]  slot [WBUF];
    logic [WBUF-1:0]   hit;

    // Only the word index selects the RAM row; the other address bits alias
    // by design. The reduction below marks them as intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aluoutm, haddr};

    // Pointer increment with wrap at WBUF, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign core_idx = aluoutm[IDX_W+1:2];
    assign host_idx = haddr[IDX_W+1:2];

    // Stall only on a full buffer. A drain in the same cycle frees a slot
    // too late for this store, so the core retries on the next cycle.
    assign full   = (count_reg == CNT_FULL);
    assign stallm = memwritem & full;
    assign accept = memwritem & ~full;

    // The host wins the write port when the buffer is empty, or once it has
    // waited long enough. live_reg keeps the RAM untouched during reset and
    // on the first edge after it.
    assign grant = live_reg & (state_reg == ST_DRAIN) & hreq &
                   ((count_reg == '0) | (waitcnt_reg == WAIT_MAX));
    assign drain = (state_reg == ST_DRAIN) & ~grant & (count_reg != '0);

    assign ram_we    = grant | drain;
    assign ram_widx  = grant ? host_idx : buf_idx[head_reg];
    assign ram_wdata = grant ? hwdata : buf_data[head_reg];

    assign hack = hack_reg;

    // Map each age position (0 = oldest) to its physical slot, and flag live
    // entries whose index matches the current core address.
    genvar gi;
    generate
        for (gi = 0; gi < WBUF; gi++) begin : g_age
            logic [PTR_W:0] sum;
            assign sum      = {1'b0, head_reg} + (PTR_W + 1)'(gi);
            assign slot[gi] = (sum >= PTR_MOD) ? PTR_W'(sum - PTR_MOD) : sum[PTR_W-1:0];
            assign hit[gi]  = (count_reg > CNT_W'(gi)) && (buf_idx[slot[gi]] == core_idx);
        end
    endgenerate

    // Load data: younger positions override older ones, and all of them
    // override RAM. A store enqueued this cycle is not yet in the buffer.
    always_comb begin
        readdatam = ram[core_idx];
        for (int k = 0; k < WBUF; k++) begin
            if (hit[k]) begin
                readdatam = buf_data[slot[k]];
            end
        end
    end

    // Single RAM write port, shared by the host grant and the buffer drain.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_widx] <= ram_wdata;
        end
    end

    // Enqueue the accepted store at the tail slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_idx[tail_reg]  <= core_idx;
            buf_data[tail_reg] <= writedatam;
        end
    end

    // FIFO pointers and occupancy; enqueue plus drain leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            if (accept) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (drain) begin
                head_reg <= ptr_inc(head_reg);
            end
            case ({accept, drain})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Arbiter FSM. The grant edge moves the FSM to HOST and raises hack for
    // exactly one cycle. The FSM then returns to DRAIN unconditionally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_DRAIN;
            hack_reg    <= 1'b0;
            waitcnt_reg <= '0;
            live_reg    <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            hack_reg <= 1'b0;
            case (state_reg)
                ST_DRAIN: begin
                    if (grant) begin
                        state_reg <= ST_HOST;
                        hack_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_DRAIN;
                end
            endcase
            if (grant) begin
                waitcnt_reg <= '0;
            end else if (hreq && (waitcnt_reg != WAIT_MAX)) begin
                waitcnt_reg <= waitcnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_wbuf_resp.sv
// Directed bench for dmem_wbuf_resp. Expected load data comes from a
// word-level memory model, queued when a load is driven and popped when
// readdatam is sampled.
module tb_dmem_wbuf_resp;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [31:0] aluoutm    = '0;
    logic [31:0] writedatam = '0;
    logic        memwritem  = 1'b0;
    logic        hreq       = 1'b0;
    logic [31:0] haddr      = '0;
    logic [31:0] hwdata     = '0;
    logic [31:0] readdatam;
    logic        stallm;
    logic        hack;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model [64];
    logic [31:0] exp_q [$];
    int          nh;
    bit          rearm;

    always #5 clk = ~clk;

    dmem_wbuf_resp dut (
        .clk        (clk),
        .reset      (reset),
        .aluoutm    (aluoutm),
        .writedatam (writedatam),
        .memwritem  (memwritem),
        .readdatam  (readdatam),
        .stallm     (stallm),
        .hreq       (hreq),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hack       (hack)
    );

    function automatic int widx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load();
        exp_q.push_back(model[widx(aluoutm)]);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed=%08h expected=<scoreboard empty>", tag, readdatam);
        end else begin
            check(tag, readdatam, exp_q.pop_front());
        end
    endtask

    task automatic load_check(input string tag, input logic [31:0] a);
        memwritem = 1'b0;
        aluoutm   = a;
        push_load();
        @(negedge clk);
        pop_check(tag);
        tick();
    endtask

    // Host write with an empty buffer: hack must follow one edge after the
    // request is raised, and it must last a single cycle.
    task automatic host_write(input logic [31:0] a, input logic [31:0] d);
        int lat;
        bit got;
        hreq   = 1'b1;
        haddr  = a;
        hwdata = d;
        lat    = 0;
        got    = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (hack) got = 1'b1;
        end
        check("host_lat", 32'(lat), 32'd1);
        hreq = 1'b0;
        if (got) model[widx(a)] = d;
        tick();
        check("hack_pulse", 32'(hack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset takes effect without a clock edge.
        #1 reset  = 1'b0;
        memwritem = 1'b1;
        aluoutm   = 32'h10;
        #1;
        check("rst_hack", 32'(hack), 32'd0);
        check("rst_stall", 32'(stallm), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        memwritem = 1'b0;
        reset     = 1'b1;
        tick();

        // Preload every word through the host port, using aliased byte
        // addresses.
        for (int i = 0; i < 64; i++) begin
            host_write(32'(i * 4 + (i % 4)) + ((i % 2 == 1) ? 32'h100 : 32'h0),
                       32'h1000_0000 + 32'(i) * 32'h0101);
        end
        load_check("pre_w0", 32'h0);
        load_check("pre_w4", 32'h13);
        load_check("pre_w63", 32'hFC);

        // A store is read back first from the buffer, then from RAM. In its
        // own cycle the store is not forwarded.
        memwritem  = 1'b1;
        aluoutm    = 32'h10;
        writedatam = 32'hDEAD_BEEF;
        push_load();
        model[4] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("a_stall", 32'(stallm), 32'd0);
        pop_check("a_nofwd");
        tick();
        load_check("a_fwd", 32'h10);
        load_check("a_ram", 32'h10);

        // Two stores to the same word: the load sees the younger one.
        memwritem  = 1'b1;
        aluoutm    = 32'h20;
        writedatam = 32'd1;
        push_load();
        model[8] = 32'd1;
        @(negedge clk);
        pop_check("c_st1");
        tick();
        writedatam = 32'd2;
        push_load();
        model[8] = 32'd2;
        @(negedge clk);
        pop_check("c_st2");
        tick();
        load_check("c_young", 32'h20);
        load_check("c_ram", 32'h20);

        // Starvation run. The host is granted at once (empty buffer), then
        // requests again while stores keep the buffer busy. It must be
        // granted after 8 waiting cycles. The grant and hack cycles block
        // drain, so the buffer fills and the store in cycle 12 stalls.
        nh     = 0;
        rearm  = 1'b0;
        hreq   = 1'b1;
        haddr  = 32'h3C;
        hwdata = 32'hC0DE_0001;
        for (int c = 0; c < 14; c++) begin
            if (hack) begin
                model[widx(haddr)] = hwdata;
                nh++;
                hreq  = 1'b0;
                rearm = (nh == 1);
            end else if (rearm) begin
                hreq   = 1'b1;
                haddr  = 32'h164;
                hwdata = 32'hC0DE_0002;
                rearm  = 1'b0;
            end
            memwritem = 1'b1;
            if (c < 10) begin
                aluoutm    = 32'h40 + 32'(4 * c);
                writedatam = 32'hA000_0000 + 32'(c);
            end else begin
                aluoutm    = 32'h74;
                writedatam = (c == 10) ? 32'hB000_0010 :
                             (c == 11) ? 32'hB000_0011 : 32'hB000_0012;
            end
            if (c >= 12) push_load();
            if (c != 12) model[widx(aluoutm)] = writedatam;
            @(negedge clk);
            check($sformatf("d_stall%0d", c), 32'(stallm), (c == 12) ? 32'd1 : 32'd0);
            check($sformatf("d_hack%0d", c), 32'(hack), (c == 1 || c == 11) ? 32'd1 : 32'd0);
            if (c >= 12) pop_check($sformatf("d_young%0d", c));
            tick();
        end
        memwritem = 1'b0;
        check("d_grants", 32'(nh), 32'd2);
        // The core store to word 25 was accepted before the host write to the
        // same word, so the store drains last and its data wins.
        model[25] = 32'hA000_0009;
        load_check("d_fwd", 32'h74);
        repeat (6) tick();
        for (int w = 15; w < 30; w++) begin
            load_check($sformatf("d_ram%0d", w), 32'(w * 4));
        end

        // Same run, with reset asserted during the second hack while 3 stores
        // are still buffered. Those stores are discarded. The host write made
        // at the grant edge stays in RAM.
        nh     = 0;
        rearm  = 1'b0;
        hreq   = 1'b1;
        haddr  = 32'hF4;
        hwdata = 32'hC0DE_0003;
        for (int c = 0; c < 12; c++) begin
            if (hack) begin
                model[widx(haddr)] = hwdata;
                nh++;
                hreq  = 1'b0;
                rearm = (nh == 1);
            end else if (rearm) begin
                hreq   = 1'b1;
                haddr  = 32'hF0;
                hwdata = 32'hC0DE_0004;
                rearm  = 1'b0;
            end
            memwritem  = (c <= 10);
            aluoutm    = 32'hA0 + 32'(4 * c);
            writedatam = 32'hE000_0000 + 32'(c);
            if (c <= 7) model[widx(aluoutm)] = writedatam;
            @(negedge clk);
            check($sformatf("e_stall%0d", c), 32'(stallm), 32'd0);
            check($sformatf("e_hack%0d", c), 32'(hack), (c == 1 || c == 11) ? 32'd1 : 32'd0);
            if (c < 11) tick();
        end
        reset     = 1'b0;
        memwritem = 1'b1;
        aluoutm   = 32'hC0;
        push_load();
        #1;
        check("e_rst_hack", 32'(hack), 32'd0);
        check("e_rst_stall", 32'(stallm), 32'd0);
        pop_check("e_rst_nofwd");
        repeat (2) @(posedge clk);
        @(negedge clk);
        memwritem = 1'b0;
        reset     = 1'b1;
        tick();
        for (int w = 40; w < 51; w++) begin
            load_check($sformatf("e_ram%0d", w), 32'(w * 4));
        end
        load_check("e_host60", 32'hF0);
        load_check("e_host61", 32'hF4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf_resp.md
DMEM_WBUF_RESP -- requirements
Module: dmem_wbuf_resp

Interface
REQ-001 SHALL have parameter WORDS, default 64, meaning RAM depth in 32-bit words (word index = aluoutm[7:2] at default).
REQ-002 SHALL have parameter WBUF, default 4, meaning posted-write buffer depth in entries.
REQ-003 SHALL have parameter STARVE, default 8, meaning the maximum number of host-wait cycles before forced host grant.
REQ-004 Port list, one clock, asynchronous active-low reset:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous active-low reset (0 = asserted)
- aluoutm  input  32  core data address (byte address)
- writedatam  input  32  core store data
- memwritem  input  1  core store request
- readdatam  output  32  load data to core (combinational)
- stallm  output  1  store not accepted this cycle; core holds store
- hreq  input  1  host (loader) write request, held until hack
- haddr  input  32  host byte address
- hwdata  input  32  host write data
- hack  output  1  one-cycle host write acknowledge

Function
REQ-005 SHALL use word index addr[log2(WORDS)+1:2] for core and host; addr[1:0] and upper bits ignored (aliasing permitted).
REQ-006 SHALL hold RAM with one synchronous write port, shared by buffer drain and host.
REQ-007 SHALL accept a store (enqueue {index,data} at tail) on a rising edge when memwritem=1 and count<WBUF.
REQ-008 SHALL drive stallm = memwritem AND (count==WBUF), combinationally; a drain in the same cycle does not clear stallm.
REQ-009 SHALL drive readdatam from the youngest buffer entry whose index matches aluoutm, else from RAM[index]; a store being enqueued in the same cycle is not forwarded.
REQ-010 Arbiter states: DRAIN (default) and HOST; one RAM write per cycle maximum.
REQ-011 In DRAIN, when count>0 and no host grant, SHALL write head entry to RAM and pop it that edge.
REQ-012 SHALL grant host (transition DRAIN->HOST) when hreq=1 and (count==0 or waitcnt==STARVE); waitcnt increments each cycle hreq=1 with no grant, saturating at STARVE.
REQ-013 In the grant cycle, SHALL write hwdata to RAM[haddr index] on that edge, suppress drain, clear waitcnt.
REQ-014 SHALL assert hack for exactly the one cycle after the grant edge (registered), state HOST; return to DRAIN on the next edge regardless of hreq.
REQ-015 SHALL not re-grant the host while hack=1; a new request needs hreq high after hack.
REQ-016 Simultaneous enqueue and drain SHALL leave count unchanged; enqueue during host grant SHALL be accepted if count<WBUF.
REQ-017 Buffer entries SHALL drain in FIFO order; a pending entry matching a host-written index overwrites the host data when it drains (program order of core stores wins).
REQ-018 Pointers SHALL wrap modulo WBUF; count range 0..WBUF.

Reset
REQ-019 reset=0 SHALL asynchronously clear count, head/tail pointers, waitcnt, hack=0, state=DRAIN; stallm then follows REQ-008 with count=0 (i.e. 0).
REQ-020 RAM contents SHALL NOT be reset; buffered stores pending at reset are discarded.
REQ-021 Reset mid host grant SHALL drop hack; the host write committed at the grant edge (if it occurred) remains in RAM.

Verification
REQ-022 Store 0xDEADBEEF to 0x10, next cycle load 0x10 -> readdatam=0xDEADBEEF from buffer; after drain, same value from RAM.
REQ-023 Five back-to-back stores with host asserting hreq continuously (drain blocked) -> stallm=1 on 5th store only when count=4; stored data retained and drained in order.
REQ-024 Stores to 0x20 values 1 then 2, load 0x20 before drain -> readdatam=2 (youngest match).
REQ-025 hreq with count=0 -> RAM write at grant edge, hack=1 exactly one cycle later, waitcnt=0.
REQ-026 Continuous core stores keeping count>0 with hreq=1 -> host granted after 8 wait cycles; hack pulses once.
REQ-027 Assert reset=0 with 3 entries buffered -> count=0, hack=0 immediately (no clock edge); loads return prior RAM values.
